// File: rtl/note_recognizer_pkg.sv
// Shared types and elaboration-time note period tables for the note period recognizer.
// Note index k = 1..36 covers C3..B5, with 12 notes per octave and C = 1 within each octave.
package note_recognizer_pkg;

    localparam int unsigned NOTE_NUM = 36;
    localparam real SEMITONE_HALF = 1.0293022366434921; // 2**(1/24)

    typedef logic [5:0] note_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DECIDE
    } fsm_state_t;

    // Octave-4 note frequencies in centi-Hz, C..B.
    function automatic int unsigned freq_100(input int unsigned n);
        case (n)
            0:       return 26163;
            1:       return 27718;
            2:       return 29366;
            3:       return 31113;
            4:       return 32963;
            5:       return 34923;
            6:       return 36999;
            7:       return 39200;
            8:       return 41530;
            9:       return 44000;
            10:      return 46616;
            11:      return 49388;
            default: return 26163;
        endcase
    endfunction

    // Nominal period in clk cycles; octave 3 doubles the octave-4 period, octave 5 halves it.
    function automatic int unsigned note_nom(input int unsigned k, input int unsigned clk_hz);
        int unsigned n;
        int unsigned oct;
        n   = (k - 1) % 12;
        oct = (k - 1) / 12;
        return $rtoi(real'(clk_hz) * 200.0 / (real'(freq_100(n)) * real'(2 ** oct)) + 0.5);
    endfunction

    function automatic int unsigned note_lo(input int unsigned k, input int unsigned clk_hz);
        return $rtoi(real'(note_nom(k, clk_hz)) / SEMITONE_HALF + 0.5);
    endfunction

    function automatic int unsigned note_hi(input int unsigned k, input int unsigned clk_hz);
        return $rtoi(real'(note_nom(k, clk_hz)) * SEMITONE_HALF + 0.5);
    endfunction

endpackage

// File: rtl/note_period_meter.sv
// Synchronises the squared audio, measures rising-edge to rising-edge period in clk cycles,
// rejects glitch edges and flags silence once the saturating counter reaches its maximum.
module note_period_meter #(
    parameter int unsigned PERIOD_W   = 20,
    parameter int unsigned MIN_PERIOD = 20_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                audio_sign,
    output logic                meas_valid,
    output logic [PERIOD_W-1:0] period,
    output logic                timeout
);
    localparam logic [PERIOD_W-1:0] MAX_PERIOD = '1;
    localparam logic [PERIOD_W-1:0] MIN_GAP    = PERIOD_W'(MIN_PERIOD);

    logic [2:0]          sync_q;
    logic [PERIOD_W-1:0] count;
    logic                armed;
    logic                rise;
    logic                accept;

    assign rise   = sync_q[1] & ~sync_q[2];
    // The arming edge is taken regardless of count so a tone starting right after reset is not lost.
    assign accept = rise && (!armed || count >= MIN_GAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            count      <= '0;
            armed      <= 1'b0;
            period     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], audio_sign};
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (accept) begin
                count <= PERIOD_W'(1);
                armed <= 1'b1;
                if (armed) begin
                    period     <= count;
                    meas_valid <= 1'b1;
                end
            end else if (count != MAX_PERIOD) begin
                count <= count + 1'b1;
                if (count == MAX_PERIOD - 1'b1) begin
                    timeout <= 1'b1;
                    armed   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/note_period_recognizer.sv
// Classifies measured audio periods into notes C3..B5 by a sequential table search and publishes
// a note index with a one-cycle step strobe once the same classification repeats STABLE_CNT times.
module note_period_recognizer
    import note_recognizer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned PERIOD_W    = 20,
    parameter int unsigned MIN_PERIOD  = 20_000,
    parameter int unsigned STABLE_CNT  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                audio_sign,
    output logic [5:0]          d2_recognize_result,
    output logic                d2_recognize_result_step,
    output logic [PERIOD_W-1:0] period_value
);
    localparam int unsigned SW = $clog2(STABLE_CNT + 1);

    logic                meas_valid;
    logic                timeout;
    logic [PERIOD_W-1:0] meas_p;

    note_period_meter #(
        .PERIOD_W  (PERIOD_W),
        .MIN_PERIOD(MIN_PERIOD)
    ) u_meter (
        .clk       (clk),
        .reset_n   (reset_n),
        .audio_sign(audio_sign),
        .meas_valid(meas_valid),
        .period    (meas_p),
        .timeout   (timeout)
    );

    assign period_value = meas_p;

    logic [31:0] lo_tab [64];
    logic [31:0] hi_tab [64];

    // Unused slots get an empty range so they can never match.
    for (genvar g = 0; g < 64; g++) begin : g_tab
        if (g >= 1 && g <= NOTE_NUM) begin : g_note
            localparam int unsigned LO = note_lo(g, CLK_FREQ_HZ);
            localparam int unsigned HI = note_hi(g, CLK_FREQ_HZ);
            assign lo_tab[g] = LO;
            assign hi_tab[g] = HI;
        end else begin : g_pad
            assign lo_tab[g] = '1;
            assign hi_tab[g] = '0;
        end
    end

    fsm_state_t          state, state_n;
    note_idx_t           k, k_n;
    note_idx_t           cand, cand_n;
    note_idx_t           last, last_n;
    note_idx_t           result_n;
    logic [SW-1:0]       stable, stable_n;
    logic [PERIOD_W-1:0] search_p, search_p_n;
    logic                step_n;
    logic                match;

    always_comb begin
        state_n    = state;
        k_n        = k;
        cand_n     = cand;
        last_n     = last;
        stable_n   = stable;
        search_p_n = search_p;
        result_n   = d2_recognize_result;
        step_n     = 1'b0;
        match      = (32'(search_p) >= lo_tab[k]) && (32'(search_p) < hi_tab[k]);

        case (state)
            IDLE: begin
                if (meas_valid) begin
                    search_p_n = meas_p;
                    k_n        = note_idx_t'(1);
                    state_n    = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    cand_n  = k;
                    state_n = DECIDE;
                end else if (k == note_idx_t'(NOTE_NUM)) begin
                    cand_n  = '0;
                    state_n = DECIDE;
                end else begin
                    k_n = k + 6'd1;
                end
            end
            DECIDE: begin
                state_n = IDLE;
                if (cand == last) begin
                    stable_n = (stable == SW'(STABLE_CNT)) ? stable : stable + 1'b1;
                end else begin
                    stable_n = SW'(1);
                    last_n   = cand;
                end
                if (stable_n == SW'(STABLE_CNT) && cand != d2_recognize_result) begin
                    result_n = cand;
                    step_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Silence overrides any decision made in the same cycle.
        if (timeout) begin
            state_n  = IDLE;
            stable_n = '0;
            last_n   = '0;
            result_n = '0;
            step_n   = (d2_recognize_result != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k                        <= '0;
            cand                     <= '0;
            last                     <= '0;
            stable                   <= '0;
            search_p                 <= '0;
            d2_recognize_result      <= '0;
            d2_recognize_result_step <= 1'b0;
        end else begin
            k                        <= k_n;
            cand                     <= cand_n;
            last                     <= last_n;
            stable                   <= stable_n;
            search_p                 <= search_p_n;
            d2_recognize_result      <= result_n;
            d2_recognize_result_step <= step_n;
        end
    end

endmodule

// File: tb/tb_note_period_recognizer.sv
// Bench for note_period_recognizer at a scaled-down clock so audio periods stay short; expected
// note events come from a period-list model built directly on the note table and stability rules.
module tb_note_period_recognizer;

    localparam int CLK_HZ  = 100_000;
    localparam int PW      = 11;
    localparam int MIN_P   = 40;
    localparam int STABLE  = 4;
    localparam int MAX_P   = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          audio_sign;
    logic [5:0]    d2_recognize_result;
    logic          d2_recognize_result_step;
    logic [PW-1:0] period_value;

    note_period_recognizer #(
        .CLK_FREQ_HZ(CLK_HZ),
        .PERIOD_W   (PW),
        .MIN_PERIOD (MIN_P),
        .STABLE_CNT (STABLE)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .audio_sign              (audio_sign),
        .d2_recognize_result     (d2_recognize_result),
        .d2_recognize_result_step(d2_recognize_result_step),
        .period_value            (period_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed step events (written only here).
    int         dut_ev[$];
    int         dut_ev_cyc[$];
    int         viol = 0;
    logic       prev_step = 1'b0;
    logic [5:0] prev_res = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_step = 1'b0;
            prev_res  = '0;
        end else begin
            if (d2_recognize_result_step) begin
                dut_ev.push_back(int'(d2_recognize_result));
                dut_ev_cyc.push_back(cyc);
                if (prev_step) viol++;
            end else if (d2_recognize_result !== prev_res) begin
                viol++;
            end
            prev_step = d2_recognize_result_step;
            prev_res  = d2_recognize_result;
        end
    end

    // Reference tables and model state.
    int freq_c[12] = '{26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388};
    int b_nom[37];
    int b_lo[37];
    int b_hi[37];

    int exp_ev[$];
    int m_res = 0, m_last = 0, m_run = 0, m_pv = 0, m_t_last = 0;
    bit m_armed = 1'b0;
    int rise_cyc[$];
    int dut_base = 0, exp_base = 0;
    int n_checks = 0, n_pass = 0;

    task automatic build_tables();
        for (int k = 1; k <= 36; k++) begin
            int  oct;
            real nom_r;
            oct      = 3 + (k - 1) / 12;
            nom_r    = real'(CLK_HZ) * 100.0 * (2.0 ** real'(4 - oct)) / real'(freq_c[(k - 1) % 12]);
            b_nom[k] = $rtoi(nom_r + 0.5);
            b_hi[k]  = $rtoi(real'(b_nom[k]) * (2.0 ** (1.0 / 24.0)) + 0.5);
            b_lo[k]  = $rtoi(real'(b_nom[k]) / (2.0 ** (1.0 / 24.0)) + 0.5);
        end
    endtask

    function automatic int classify(input int p);
        for (int k = 1; k <= 36; k++)
            if (p >= b_lo[k] && p < b_hi[k]) return k;
        return 0;
    endfunction

    task automatic model_timeout();
        if (m_res != 0) begin
            m_res = 0;
            exp_ev.push_back(0);
        end
        m_last  = 0;
        m_run   = 0;
        m_armed = 1'b0;
    endtask

    task automatic model_tick(input int t);
        if (m_armed && t - m_t_last >= MAX_P) model_timeout();
    endtask

    task automatic model_edge(input int t);
        int g, c;
        model_tick(t);
        g = t - m_t_last;
        if (!m_armed) begin
            m_armed  = 1'b1;
            m_t_last = t;
        end else if (g >= MIN_P) begin
            m_t_last = t;
            m_pv     = g;
            c        = classify(g);
            if (c == m_last) m_run = (m_run < STABLE) ? m_run + 1 : STABLE;
            else begin
                m_run  = 1;
                m_last = c;
            end
            if (m_run == STABLE && c != m_res) begin
                m_res = c;
                exp_ev.push_back(c);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tone(input int p, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            audio_sign = 1'b1;
            rise_cyc.push_back(cyc);
            model_edge(cyc);
            if (glitch) begin
                repeat (8) @(negedge clk);
                audio_sign = 1'b0;
                repeat (2) @(negedge clk);
                audio_sign = 1'b1;
                model_edge(cyc);
                repeat (p / 2 - 10) @(negedge clk);
            end else begin
                repeat (p / 2) @(negedge clk);
            end
            audio_sign = 1'b0;
            repeat (p - p / 2 - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int c);
        audio_sign = 1'b0;
        repeat (c) @(negedge clk);
        model_tick(cyc);
    endtask

    // Compares all step events since the previous checkpoint, then the current outputs.
    task automatic checkpoint(input string tag);
        int nd, ne;
        nd = dut_ev.size() - dut_base;
        ne = exp_ev.size() - exp_base;
        check({tag, "_nev"}, nd, ne);
        for (int i = 0; i < nd && i < ne; i++)
            check({tag, "_ev"}, dut_ev[dut_base + i], exp_ev[exp_base + i]);
        check({tag, "_res"}, d2_recognize_result, m_res);
        check({tag, "_pv"}, period_value, m_pv);
        check({tag, "_steprule"}, viol, 0);
        dut_base = dut_ev.size();
        exp_base = exp_ev.size();
    endtask

    initial begin
        int p, base, lat;
        build_tables();
        reset_n    = 1'b0;
        audio_sign = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res", d2_recognize_result, 0);
        check("rst_step", d2_recognize_result_step, 0);
        check("rst_pv", period_value, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // A4 for six periods: one step to 22 shortly after the fifth rising edge.
        rise_cyc.delete();
        base = dut_ev.size();
        tone(b_nom[22], 6, 1'b0);
        idle(50);
        check("a4_period", period_value, 227);
        check("a4_res", d2_recognize_result, 22);
        lat = (dut_ev_cyc.size() > base) ? dut_ev_cyc[base] - rise_cyc[4] : 9999;
        check("a4_latency_le38", (lat >= 1 && lat <= 38), 1);
        checkpoint("a4");

        // Silence well past the counter maximum: single step back to 0.
        idle(MAX_P + 200);
        check("silence_res", d2_recognize_result, 0);
        checkpoint("silence");

        // A4 with a glitch edge inside every high phase; glitches must not disturb the result.
        tone(b_nom[22], 6, 1'b1);
        idle(50);
        check("glitch_res", d2_recognize_result, 22);
        checkpoint("glitch");

        // Alternating A4/B4: never stable, result holds.
        for (int i = 0; i < 10; i++) begin
            tone(b_nom[22], 1, 1'b0);
            tone(b_nom[24], 1, 1'b0);
        end
        idle(50);
        check("alt_res", d2_recognize_result, 22);
        checkpoint("alt");

        // C3 then B5: steps to 1 and then to 36.
        base = dut_ev.size();
        tone(b_nom[1], 6, 1'b0);
        tone(b_nom[36], 6, 1'b0);
        idle(50);
        check("c3b5_first", (dut_ev.size() > base) ? dut_ev[base] : 99, 1);
        check("c3b5_second", (dut_ev.size() > base + 1) ? dut_ev[base + 1] : 99, 36);
        checkpoint("c3b5");

        // Randomised tone segments, mostly near table notes, some arbitrary periods.
        for (int s = 0; s < 6; s++) begin
            if ($urandom_range(0, 3) != 0)
                p = b_nom[$urandom_range(1, 36)] + int'($urandom_range(0, 4)) - 2;
            else
                p = int'($urandom_range(45, 900));
            tone(p, int'($urandom_range(3, 5)), 1'b0);
        end
        idle(60);
        checkpoint("rand");

        // Silence, then a 60 Hz tone whose period lies beyond every note: stays 0.
        idle(MAX_P + 200);
        checkpoint("pre60");
        tone(1667, 3, 1'b0);
        idle(50);
        check("hz60_res", d2_recognize_result, 0);
        checkpoint("hz60");

        // Reach 22 again, then pull reset while a new measurement is being searched.
        tone(b_nom[22], 6, 1'b0);
        idle(20);
        checkpoint("pre_rst");
        @(negedge clk);
        audio_sign = 1'b1;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_search_res", d2_recognize_result, 0);
        check("rst_search_step", d2_recognize_result_step, 0);
        check("rst_search_pv", period_value, 0);
        audio_sign = 1'b0;
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        m_res    = 0;
        m_last   = 0;
        m_run    = 0;
        m_pv     = 0;
        m_armed  = 1'b0;
        idle(50);
        checkpoint("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
